// File: rtl/game_key_debounce.sv
// Pushbutton debouncer with registered level, press/release pulses and optional auto-repeat.
// A 2-flop synchronizer feeds a four-state debounce FSM sharing one debounce counter.
module game_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int REPEAT_ENABLE   = 1,
  parameter int CNT_W           = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_repeat
);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam bit               REP_ON  = (REPEAT_ENABLE != 0);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             sync_pressed;
  state_t           state_reg;
  logic [CNT_W-1:0] dcnt_reg;
  logic [CNT_W-1:0] rcnt_reg;
  logic             first_done_reg;
  logic [CNT_W-1:0] rcnt_limit;

  // Synchronizer resets to the released level so a held key is not seen until after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key_raw_n;
      sync2_reg <= sync1_reg;
    end
  end

  assign sync_pressed = ~sync2_reg;
  assign rcnt_limit   = first_done_reg ? RP_LAST : RD_LAST;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= RELEASED;
      dcnt_reg       <= '0;
      rcnt_reg       <= '0;
      first_done_reg <= 1'b0;
      key_level      <= 1'b0;
      key_press      <= 1'b0;
      key_release    <= 1'b0;
      key_repeat     <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      case (state_reg)
        RELEASED: begin
          if (sync_pressed) begin
            state_reg <= DB_PRESS;
            dcnt_reg  <= '0;
          end
        end
        DB_PRESS: begin
          if (!sync_pressed) begin
            state_reg <= RELEASED;
          end else if (dcnt_reg == DB_LAST) begin
            state_reg      <= HELD;
            key_level      <= 1'b1;
            key_press      <= 1'b1;
            rcnt_reg       <= '0;
            first_done_reg <= 1'b0;
          end else begin
            dcnt_reg <= dcnt_reg + 1'b1;
          end
        end
        HELD: begin
          // Leaving for release debounce freezes rcnt so a bounce resumes repeat timing.
          if (!sync_pressed) begin
            state_reg <= DB_RELEASE;
            dcnt_reg  <= '0;
          end else if (REP_ON) begin
            if (rcnt_reg == rcnt_limit) begin
              key_repeat     <= 1'b1;
              rcnt_reg       <= '0;
              first_done_reg <= 1'b1;
            end else begin
              rcnt_reg <= rcnt_reg + 1'b1;
            end
          end
        end
        DB_RELEASE: begin
          if (sync_pressed) begin
            state_reg <= HELD;
          end else if (dcnt_reg == DB_LAST) begin
            state_reg   <= RELEASED;
            key_level   <= 1'b0;
            key_release <= 1'b1;
          end else begin
            dcnt_reg <= dcnt_reg + 1'b1;
          end
        end
        default: state_reg <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_game_key_debounce.sv
// Bench for game_key_debounce: spec-derived vector table, directed corner sequences,
// and randomized key activity checked against a run-length reference model.
module tb_game_key_debounce;

  localparam int D   = 4;
  localparam int DLY = 10;
  localparam int P   = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic key_raw_n = 1'b1;
  logic lvl1, prs1, rel1, rep1;
  logic lvl0, prs0, rel0, rep0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_key_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(P),
                      .REPEAT_ENABLE(1), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .key_raw_n(key_raw_n),
    .key_level(lvl1), .key_press(prs1), .key_release(rel1), .key_repeat(rep1));

  game_key_debounce #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(P),
                      .REPEAT_ENABLE(0), .CNT_W(8)) dut_nr (
    .clk(clk), .reset_n(reset_n), .key_raw_n(key_raw_n),
    .key_level(lvl0), .key_press(prs0), .key_release(rel0), .key_repeat(rep0));

  // Reference: a level flips after D+1 consecutive synchronized samples that disagree with it;
  // repeats count steady held edges (not the edge that ends a release bounce).
  typedef struct {
    bit s1, s2, lvl, fd;
    int run, hc;
    bit [3:0] out;
  } model_t;

  typedef struct {
    bit raw;
    bit [3:0] exp;
    bit [3:0] exp_nr;
  } vec_t;

  model_t m1, m0;
  vec_t vecs[40];

  function automatic void model_reset(output model_t m);
    m.s1 = 1'b1; m.s2 = 1'b1; m.lvl = 1'b0; m.fd = 1'b0;
    m.run = 0; m.hc = 0; m.out = 4'b0;
  endfunction

  function automatic void model_step(inout model_t m, input bit raw, input bit rep_en);
    bit sp, press, rel, rep;
    press = 1'b0; rel = 1'b0; rep = 1'b0;
    sp = !m.s2;
    if (sp != m.lvl) begin
      m.run++;
      if (m.run == D + 1) begin
        m.lvl = sp;
        m.run = 0;
        if (sp) begin press = 1'b1; m.hc = 0; m.fd = 1'b0; end
        else rel = 1'b1;
      end
    end else begin
      if (m.lvl && m.run == 0 && rep_en) begin
        m.hc++;
        if (m.hc == (m.fd ? P : DLY)) begin rep = 1'b1; m.hc = 0; m.fd = 1'b1; end
      end
      m.run = 0;
    end
    m.s2 = m.s1;
    m.s1 = raw;
    m.out = {m.lvl, press, rel, rep};
  endfunction

  function automatic bit [3:0] o1();
    return {lvl1, prs1, rel1, rep1};
  endfunction

  function automatic bit [3:0] o0();
    return {lvl0, prs0, rel0, rep0};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One rising edge with raw sampled on it; returns at edge+1 so outputs are settled.
  task automatic step(input bit raw);
    key_raw_n = raw;
    @(posedge clk);
    model_step(m1, raw, 1'b1);
    model_step(m0, raw, 1'b0);
    #1;
  endtask

  // Asserts reset between edges, checks the asynchronous clear, then releases after two edges.
  task automatic pulse_reset(input bit raw);
    key_raw_n = raw;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'(o1()), 0);
    chk("async_reset_outputs_nr", int'(o0()), 0);
    model_reset(m1);
    model_reset(m0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt_p, cnt_r, cnt_rep, any_act, lvl_low, press_edge;
    bit raw;
    int len;

    model_reset(m1);
    model_reset(m0);

    // Clean press at edge 7, repeats at 17,20,...; release from edge R=31 lands at R+6.
    for (int e = 1; e <= 40; e++) begin
      bit l, pr, rl, rp;
      l  = (e >= 7 && e <= 36);
      pr = (e == 7);
      rl = (e == 37);
      rp = (e == 17 || e == 20 || e == 23 || e == 26 || e == 29 || e == 32);
      vecs[e-1].raw    = (e < 31) ? 1'b0 : 1'b1;
      vecs[e-1].exp    = {l, pr, rl, rp};
      vecs[e-1].exp_nr = {l, pr, rl, 1'b0};
    end

    #2;
    chk("reset_state", int'(o1()), 0);
    chk("reset_state_nr", int'(o0()), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1);

    for (int i = 0; i < 40; i++) begin
      step(vecs[i].raw);
      $display("vec edge %0d raw=%0b dut=%b exp=%b nr=%b exp_nr=%b",
               i + 1, vecs[i].raw, o1(), vecs[i].exp, o0(), vecs[i].exp_nr);
      chk($sformatf("vec_edge%0d", i + 1), int'(o1()), int'(vecs[i].exp));
      chk($sformatf("vec_nr_edge%0d", i + 1), int'(o0()), int'(vecs[i].exp_nr));
    end
    for (int i = 0; i < 5; i++) step(1'b1);

    // Press bounce: three low samples then high must leave every output idle.
    any_act = 0;
    for (int i = 0; i < 15; i++) begin
      step((i < 3) ? 1'b0 : 1'b1);
      if (o1() != 0) any_act++;
    end
    $display("seq press_bounce activity=%0d", any_act);
    chk("press_bounce_activity", any_act, 0);

    // Release bounce: two high samples while held keep the level with no extra pulses.
    for (int i = 0; i < 12; i++) step(1'b0);
    chk("held_before_bounce", int'(lvl1), 1);
    cnt_p = 0; cnt_r = 0; lvl_low = 0;
    for (int i = 0; i < 14; i++) begin
      step((i < 2) ? 1'b1 : 1'b0);
      cnt_p += int'(prs1); cnt_r += int'(rel1); lvl_low += int'(!lvl1);
    end
    $display("seq release_bounce press=%0d release=%0d low=%0d", cnt_p, cnt_r, lvl_low);
    chk("release_bounce_press", cnt_p, 0);
    chk("release_bounce_release", cnt_r, 0);
    chk("release_bounce_level", lvl_low, 0);

    // Reset while held: async clear, then a full debounce before the next press.
    chk("held_before_reset", int'(lvl1), 1);
    pulse_reset(1'b0);
    press_edge = 0;
    for (int e = 1; e <= 10; e++) begin
      step(1'b0);
      if (prs1 && press_edge == 0) press_edge = e;
    end
    $display("seq reset_while_held press_edge=%0d", press_edge);
    chk("reset_held_press_edge", press_edge, 7);

    // Repeat disabled: 40-cycle hold gives one press, no repeats, one release.
    pulse_reset(1'b1);
    for (int i = 0; i < 4; i++) step(1'b1);
    cnt_p = 0; cnt_r = 0; cnt_rep = 0;
    for (int i = 0; i < 55; i++) begin
      step((i < 40) ? 1'b0 : 1'b1);
      cnt_p += int'(prs0); cnt_r += int'(rel0); cnt_rep += int'(rep0);
    end
    $display("seq no_repeat press=%0d repeat=%0d release=%0d", cnt_p, cnt_rep, cnt_r);
    chk("norep_press", cnt_p, 1);
    chk("norep_repeat", cnt_rep, 0);
    chk("norep_release", cnt_r, 1);

    // Randomized bursts against the reference model.
    for (int b = 0; b < 300; b++) begin
      int bad_before;
      bad_before = n_bad;
      if ($urandom_range(0, 39) == 0) begin
        pulse_reset($urandom_range(0, 1) == 1);
        len = 0;
      end else begin
        raw = ($urandom_range(0, 1) == 1);
        len = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 35) : $urandom_range(1, 7);
        for (int i = 0; i < len; i++) begin
          step(raw);
          chk("rand_dut", int'(o1()), int'(m1.out));
          chk("rand_dut_nr", int'(o0()), int'(m0.out));
        end
      end
      $display("burst %0d raw=%0b len=%0d level=%0b new_errors=%0d",
               b, key_raw_n, len, lvl1, n_bad - bad_before);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
